// File: rtl/puf_response_voter.sv
// puf_response_voter: arm/fire sequencer for the DAPUF array with a per-bit
// majority vote over NUM_SAMPLES evaluations and a valid/ready key output.
// Optional feature macro: UNSTABLE_MASK_EN (adds the unstable_mask output).
module puf_response_voter #(
    parameter int WIDTH         = 64,
    parameter int NUM_SAMPLES   = 15,
    parameter int ARM_CYCLES    = 19,
    parameter int SETTLE_CYCLES = 30
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             start,
    input  logic [WIDTH-1:0] resp_in,
    output logic             excite_l,
    output logic             excite_r,
    output logic             busy,
    output logic [WIDTH-1:0] key_out,
    output logic             key_valid,
    input  logic             key_ready
`ifdef UNSTABLE_MASK_EN
    ,
    output logic [WIDTH-1:0] unstable_mask
`endif
);

    localparam int CW    = $clog2(NUM_SAMPLES + 1);
    localparam int TMAX  = (ARM_CYCLES > SETTLE_CYCLES) ? ARM_CYCLES : SETTLE_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, ARM, FIRE, SAMPLE, DONE} state_t;

    state_t                     state, state_nxt;
    logic [TW-1:0]              timer;
    logic [CW-1:0]              sample_cnt;
    logic                       last_sample;
    logic                       excite_q;
    logic [WIDTH-1:0][CW-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]           vote;

    assign last_sample = (sample_cnt + CW'(1)) == CW'(NUM_SAMPLES);

    // Per-bit vote counters: next count and the majority decision on it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign cnt_nxt[i] = cnt[i] + CW'(resp_in[i]);
        assign vote[i]    = cnt_nxt[i] > CW'(NUM_SAMPLES / 2);
    end

`ifdef UNSTABLE_MASK_EN
    logic [WIDTH-1:0] unstable;
    for (genvar i = 0; i < WIDTH; i++) begin : g_unstable
        assign unstable[i] = (cnt_nxt[i] != '0) && (cnt_nxt[i] != CW'(NUM_SAMPLES));
    end
`endif

    // Next-state logic for the arm/fire/sample sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     if (timer == TW'(ARM_CYCLES - 1)) state_nxt = FIRE;
            FIRE:    if (timer == TW'(SETTLE_CYCLES - 1)) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_sample ? DONE : ARM;
            DONE:    if (key_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, phase timer, excite register, vote counters and key capture.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state      <= IDLE;
            timer      <= '0;
            sample_cnt <= '0;
            cnt        <= '0;
            excite_q   <= 1'b1;
            key_out    <= '0;
`ifdef UNSTABLE_MASK_EN
            unstable_mask <= '0;
`endif
        end else begin
            state <= state_nxt;
            // Timer restarts on every phase change, so each ARM/FIRE starts at 0.
            if ((state == ARM || state == FIRE) && state_nxt == state)
                timer <= timer + TW'(1);
            else
                timer <= '0;
            // Registered from next state so excite changes exactly on phase entry.
            excite_q <= (state_nxt != ARM);
            if (state == IDLE && start) begin
                cnt        <= '0;
                sample_cnt <= '0;
            end
            if (state == SAMPLE) begin
                cnt        <= cnt_nxt;
                sample_cnt <= sample_cnt + CW'(1);
                // Final sample folds straight into the key so it is ready on DONE entry.
                if (last_sample) begin
                    key_out <= vote;
`ifdef UNSTABLE_MASK_EN
                    unstable_mask <= unstable;
`endif
                end
            end
        end
    end

    assign excite_l  = excite_q;
    assign excite_r  = excite_q;
    assign key_valid = (state == DONE);
    assign busy      = (state == ARM) || (state == FIRE) || (state == SAMPLE);

endmodule

// File: tb/tb_puf_response_voter.sv
// Bench for puf_response_voter: table vectors, random votes against a
// count-the-ones model, excite timing, backpressure, mid-run reset, stray start.
module tb_puf_response_voter;

    localparam int W   = 64;
    localparam int NS  = 3;
    localparam int ARM = 19;
    localparam int SET = 30;
    localparam int PER = ARM + SET + 1;

    logic         Clk = 1'b0;
    logic         RstN = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] resp_in = '0;
    logic         excite_l, excite_r, busy, key_valid;
    logic         key_ready = 1'b0;
    logic [W-1:0] key_out;
`ifdef UNSTABLE_MASK_EN
    logic [W-1:0] unstable_mask;
`endif

    int total = 0;
    int bad   = 0;

    puf_response_voter #(.WIDTH(W), .NUM_SAMPLES(NS), .ARM_CYCLES(ARM),
                         .SETTLE_CYCLES(SET)) dut (
        .Clk(Clk), .RstN(RstN), .start(start), .resp_in(resp_in),
        .excite_l(excite_l), .excite_r(excite_r), .busy(busy),
        .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready)
`ifdef UNSTABLE_MASK_EN
        , .unstable_mask(unstable_mask)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [NS-1:0][W-1:0] s;
        logic [W-1:0]         key;
        logic [W-1:0]         mask;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] junk();
        return {$urandom, $urandom};
    endfunction

    // Reference: count ones per bit over all samples, then majority / unanimity.
    function automatic void model(input logic [NS-1:0][W-1:0] s,
                                  output logic [W-1:0] key, output logic [W-1:0] mask);
        for (int b = 0; b < W; b++) begin
            int ones = 0;
            for (int k = 0; k < NS; k++) ones += int'(s[k][b]);
            key[b]  = (ones > NS / 2);
            mask[b] = (ones != 0) && (ones != NS);
        end
    endfunction

    // One full key run; resp_in carries the real sample only in the cycle before
    // each sampling edge and junk otherwise.
    task automatic run(input string tag, input logic [NS-1:0][W-1:0] s,
                       input logic [W-1:0] exp_key, input logic [W-1:0] exp_mask,
                       input bit stray_start, input int hold);
        int exc_bad = 0, lr_bad = 0, early = 0, unstable_cnt = 0, after = 0;
        logic [W-1:0] held;
        @(negedge Clk); start = 1'b1; resp_in = junk();
        @(posedge Clk);
        for (int p = 0; p < PER * NS; p++) begin
            @(negedge Clk);
            start = stray_start && (p == PER + 7);
            if (excite_l !== 1'((p % PER) >= ARM)) exc_bad++;
            if (excite_l !== excite_r) lr_bad++;
            if (key_valid !== 1'b0 || busy !== 1'b1) early++;
            resp_in = ((p % PER) == PER - 1) ? s[p / PER] : junk();
            @(posedge Clk);
        end
        @(negedge Clk);
        start = 1'b0;
        check({tag, ".excite_timing"}, W'(exc_bad), '0);
        check({tag, ".excite_lr"}, W'(lr_bad), '0);
        check({tag, ".no_early_valid"}, W'(early), '0);
        check({tag, ".valid_at_latency"}, W'(key_valid), W'(1));
        check({tag, ".busy_done"}, W'(busy), '0);
        check({tag, ".key"}, key_out, exp_key);
`ifdef UNSTABLE_MASK_EN
        check({tag, ".mask"}, unstable_mask, exp_mask);
`endif
        held = key_out;
        for (int h = 0; h < hold; h++) begin
            resp_in = junk();
            start = (h == 5);
            @(posedge Clk);
            @(negedge Clk);
            if (key_valid !== 1'b1 || key_out !== held || busy !== 1'b0 || excite_l !== 1'b1)
                unstable_cnt++;
        end
        if (hold > 0) check({tag, ".backpressure_hold"}, W'(unstable_cnt), '0);
        // Handshake with start in the same cycle: start must be ignored.
        key_ready = 1'b1; start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        key_ready = 1'b0; start = 1'b0;
        check({tag, ".valid_drop"}, W'(key_valid), '0);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (busy !== 1'b0 || key_valid !== 1'b0 || excite_l !== 1'b1) after++;
        end
        check({tag, ".idle_after"}, W'(after), '0);
    endtask

    initial begin
        logic [W-1:0] k, m;
        logic [NS-1:0][W-1:0] rs;
        int post = 0;

        tbl[0] = '{s: {64'hDEADBEEF0000FFFF, 64'hDEADBEEF0000FFFF, 64'hDEADBEEF0000FFFF},
                   key: 64'hDEADBEEF0000FFFF, mask: 64'h0};
        tbl[1] = '{s: {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA},
                   key: 64'hAAAAAAAAAAAAAAAA, mask: 64'hFFFFFFFFFFFFFFFF};
        tbl[2] = '{s: {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF},
                   key: 64'hFFFFFFFFFFFFFFFF, mask: 64'h0};
        tbl[3] = '{s: {64'h0, 64'h0, 64'h0}, key: 64'h0, mask: 64'h0};
        tbl[4] = '{s: {64'hFFFF0000FFFF0000, 64'hFF00FF00FF00FF00, 64'hF0F0F0F0F0F0F0F0},
                   key: 64'hFFF0F000FFF0F000, mask: 64'h0FFFFFF00FFFFFF0};
        tbl[5] = '{s: {64'h8000000000000001, 64'h8000000000000000, 64'h0000000000000001},
                   key: 64'h8000000000000001, mask: 64'h8000000000000001};

        // Reset state.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst.excite_l", W'(excite_l), W'(1));
        check("rst.excite_r", W'(excite_r), W'(1));
        check("rst.busy", W'(busy), '0);
        check("rst.key_valid", W'(key_valid), '0);
        check("rst.key_out", key_out, '0);
`ifdef UNSTABLE_MASK_EN
        check("rst.mask", unstable_mask, '0);
`endif
        RstN = 1'b1;

        // Table vectors; first has backpressure, second has a stray start.
        for (int t = 0; t < 6; t++)
            run($sformatf("tbl%0d", t), tbl[t].s, tbl[t].key, tbl[t].mask,
                t == 1, (t == 0) ? 40 : 0);

        // Reset during the second FIRE phase.
        @(negedge Clk); start = 1'b1; resp_in = 64'hFFFFFFFFFFFFFFFF;
        @(posedge Clk);
        @(negedge Clk); start = 1'b0;
        repeat (PER + ARM + 5) @(posedge Clk);
        @(negedge Clk); RstN = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("midrst.excite", W'(excite_l & excite_r), W'(1));
        check("midrst.busy", W'(busy), '0);
        check("midrst.key_valid", W'(key_valid), '0);
        RstN = 1'b1;
        for (int i = 0; i < 2 * PER; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (key_valid !== 1'b0 || busy !== 1'b0) post++;
        end
        check("midrst.stays_idle", W'(post), '0);
        run("fresh", tbl[4].s, tbl[4].key, tbl[4].mask, 1'b0, 0);

        // Random samples against the model, with some biased words.
        for (int r = 0; r < 8; r++) begin
            logic [W-1:0] base;
            base = junk();
            for (int j = 0; j < NS; j++)
                rs[j] = (r % 2 == 0) ? junk() : (base ^ (junk() & junk() & junk()));
            model(rs, k, m);
            run($sformatf("rnd%0d", r), rs, k, m, r == 3, (r == 5) ? 7 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
